multicycle_sequencer: RTL

//  Multi-cycle control sequencer for the 8-bit processor datapath. Steps each instruction

---
 rtl/seq_pkg.sv | 43 ++++
 rtl/opcode_class_decode.sv | 28 ++
 rtl/multicycle_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// ----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the multi-cycle control sequencer:
//   - the opcodes the sequencer recognises (IR[6:0])
//   - the instruction class enum produced by the opcode decoder
//   - the sequencer state enum
//   - the two ALU operation codes driven on aluop
//   - a helper that says whether a class needs a data-memory phase
// ----------------------------------------------------------------------------
package seq_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    typedef enum logic [2:0] {
        CLS_LOAD    = 3'd0,
        CLS_STORE   = 3'd1,
        CLS_RTYPE   = 3'd2,
        CLS_ITYPE   = 3'd3,
        CLS_ILLEGAL = 3'd4
    } instr_class_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_FAULT  = 3'd6
    } seq_state_t;

    // Classes that go through the data-memory phase after EXEC.
    function automatic logic class_uses_mem(input instr_class_t cls);
        return (cls == CLS_LOAD) || (cls == CLS_STORE);
    endfunction

endpackage

// File: rtl/opcode_class_decode.sv
// ----------------------------------------------------------------------------
// opcode_class_decode
// Purely combinational opcode -> instruction class decode. Anything that is
// not one of the four supported opcodes maps to CLS_ILLEGAL.
// Ports:
//   i_opcode  in  7  IR[6:0]
//   o_class   out 3  instr_class_t encoding
// ----------------------------------------------------------------------------
module opcode_class_decode
    import seq_pkg::*;
(
    input  logic [6:0] i_opcode,
    output logic [2:0] o_class
);

    // Map the opcode to its class; unknown encodings are illegal.
    always_comb begin
        o_class = CLS_ILLEGAL;
        case (i_opcode)
            OP_LOAD:  o_class = CLS_LOAD;
            OP_STORE: o_class = CLS_STORE;
            OP_RTYPE: o_class = CLS_RTYPE;
            OP_ITYPE: o_class = CLS_ITYPE;
            default:  o_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// ----------------------------------------------------------------------------
// multicycle_sequencer
// Multi-cycle control sequencer for the 8-bit datapath. Each instruction walks
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB); datapath controls are decoded from
// the registered state and the registered instruction class. Only ir_write,
// pc_write and instr_done also depend on the current cycle's memory ack.
// Illegal opcodes and memory requests left unacknowledged for MEM_TIMEOUT
// cycles park the sequencer in FAULT until clear_fault.
// Parameters:
//   MEM_TIMEOUT  cycles a request may stay unacknowledged (>= 1)
//   CNT_W        width of the retired-instruction counter
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   en                    run instructions while high
//   clear_fault           pulse, FAULT -> IDLE
//   opcode[6:0]           IR[6:0], valid the cycle after ir_write
//   imem_req / imem_ack   instruction fetch handshake
//   dmem_req / dmem_ack   data access handshake
//   ir_write, pc_write    IR load / PC advance strobes
//   memread, memwrite     data memory direction
//   memtoreg, alu_src     writeback source / ALU B source
//   regwrite, aluop[1:0]  register write enable / ALU operation
//   busy, instr_done      activity level / retirement pulse
//   illegal_op, bus_error fault cause flags (held while in FAULT)
//   instr_count           retired instruction count, wraps
// ----------------------------------------------------------------------------
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clear_fault,
    input  logic [6:0]       opcode,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             dmem_req,
    input  logic             dmem_ack,
    output logic             ir_write,
    output logic             pc_write,
    output logic             memread,
    output logic             memwrite,
    output logic             memtoreg,
    output logic             alu_src,
    output logic             regwrite,
    output logic [1:0]       aluop,
    output logic             busy,
    output logic             instr_done,
    output logic             illegal_op,
    output logic             bus_error,
    output logic [CNT_W-1:0] instr_count
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    // Last count value that may still be followed by an ack without faulting.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    seq_state_t         r_state;
    seq_state_t         w_next;
    instr_class_t       r_class;
    instr_class_t       w_class;
    logic [2:0]         w_class_raw;
    logic [WAIT_W-1:0]  r_wait;
    logic               r_illegal;
    logic               r_bus_err;
    logic [CNT_W-1:0]   r_count;
    logic               w_req;
    logic               w_ack;
    logic               w_timeout;
    logic               w_retire;

    opcode_class_decode u_decode (
        .i_opcode (opcode),
        .o_class  (w_class_raw)
    );

    assign w_class = instr_class_t'(w_class_raw);

    // Handshake bookkeeping: outstanding request, its ack, timeout and retirement.
    always_comb begin
        w_req     = (r_state == ST_FETCH) || (r_state == ST_MEM);
        w_ack     = ((r_state == ST_FETCH) && imem_ack) ||
                    ((r_state == ST_MEM) && dmem_ack);
        // An ack arriving on the final allowed cycle wins over the timeout.
        w_timeout = w_req && !w_ack && (r_wait == WAIT_LAST);
        w_retire  = (r_state == ST_WB) ||
                    ((r_state == ST_MEM) && (r_class == CLS_STORE) && dmem_ack);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (en) w_next = ST_FETCH;
                else    w_next = ST_IDLE;
            end
            ST_FETCH: begin
                if (imem_ack)       w_next = ST_DECODE;
                else if (w_timeout) w_next = ST_FAULT;
                else                w_next = ST_FETCH;
            end
            ST_DECODE: begin
                if (w_class == CLS_ILLEGAL) w_next = ST_FAULT;
                else                        w_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (class_uses_mem(r_class)) w_next = ST_MEM;
                else                         w_next = ST_WB;
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    // A load still has to write back; a store retires here.
                    if (r_class == CLS_LOAD) w_next = ST_WB;
                    else if (en)             w_next = ST_FETCH;
                    else                     w_next = ST_IDLE;
                end else if (w_timeout) begin
                    w_next = ST_FAULT;
                end else begin
                    w_next = ST_MEM;
                end
            end
            ST_WB: begin
                if (en) w_next = ST_FETCH;
                else    w_next = ST_IDLE;
            end
            ST_FAULT: begin
                if (clear_fault) w_next = ST_IDLE;
                else             w_next = ST_FAULT;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Instruction class register, captured while the opcode is valid in DECODE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_class <= CLS_ILLEGAL;
        end else if (r_state == ST_DECODE) begin
            r_class <= w_class;
        end else begin
            r_class <= r_class;
        end
    end

    // Request wait counter: counts unacked request cycles, cleared on any state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait <= '0;
        end else if (w_next != r_state) begin
            r_wait <= '0;
        end else if (w_req && !w_ack) begin
            r_wait <= r_wait + WAIT_ONE;
        end else begin
            r_wait <= '0;
        end
    end

    // Fault cause flags: set on entry to FAULT, held there, cleared on exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
        end else if (r_state == ST_FAULT) begin
            if (clear_fault) begin
                r_illegal <= 1'b0;
                r_bus_err <= 1'b0;
            end else begin
                r_illegal <= r_illegal;
                r_bus_err <= r_bus_err;
            end
        end else begin
            r_illegal <= (r_state == ST_DECODE) && (w_class == CLS_ILLEGAL);
            r_bus_err <= w_timeout;
        end
    end

    // Retired-instruction counter, wraps naturally at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_retire) begin
            r_count <= r_count + CNT_ONE;
        end else begin
            r_count <= r_count;
        end
    end

    // Output decode from registered state and class.
    always_comb begin
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        memtoreg    = 1'b0;
        alu_src     = 1'b0;
        regwrite    = 1'b0;
        aluop       = ALUOP_ADD;
        instr_done  = 1'b0;
        busy        = (r_state != ST_IDLE) && (r_state != ST_FAULT);
        illegal_op  = r_illegal;
        bus_error   = r_bus_err;
        instr_count = r_count;
        case (r_state)
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ack;
            end
            ST_EXEC: begin
                alu_src = (r_class != CLS_RTYPE);
                aluop   = (r_class == CLS_RTYPE) ? ALUOP_RTYPE : ALUOP_ADD;
            end
            ST_MEM: begin
                // Address is base + immediate, so the ALU keeps the immediate operand.
                dmem_req   = 1'b1;
                alu_src    = 1'b1;
                memread    = (r_class == CLS_LOAD);
                memwrite   = (r_class == CLS_STORE);
                pc_write   = w_retire;
                instr_done = w_retire;
            end
            ST_WB: begin
                regwrite   = 1'b1;
                memtoreg   = (r_class == CLS_LOAD);
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

endmodule
